// File: rtl/eaglesong_pkg.sv
// Shared dimensions, state type, FSM encoding and rotate helper for the Eaglesong circulant stage.
package eaglesong_pkg;

    localparam int WORDS          = 16;
    localparam int WORD_W         = 32;
    localparam int COEFS_PER_WORD = 3;
    localparam int NUM_COEFS      = WORDS * COEFS_PER_WORD;
    localparam int COEF_IDX_W     = 7;
    localparam int COEF_W         = 5;
    localparam int WORD_IDX_W     = 4;
    localparam int K_W            = 2;

    typedef logic [WORDS-1:0][WORD_W-1:0] state_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_e;

    // Rotate left; the upper half of the doubled word shifted by s is the rotated word.
    function automatic logic [WORD_W-1:0] rotl32(input logic [WORD_W-1:0] w,
                                                 input logic [COEF_W-1:0] s);
        logic [2*WORD_W-1:0] dbl;
        dbl = {w, w} << s;
        return dbl[2*WORD_W-1:WORD_W];
    endfunction

endpackage

// File: rtl/eaglesong_coefficients.sv
// Combinational lookup of the 48 Eaglesong circulant rotation amounts.
// Zero latency; out-of-range indices return 0 (identity rotate).
module eaglesong_coefficients
    import eaglesong_pkg::*;
(
    input  logic [COEF_IDX_W-1:0] idx_i,
    output logic [COEF_W-1:0]     coef_o
);

    always_comb begin
        coef_o = '0;
        case (idx_i)
            7'd0:  coef_o = 5'd0;
            7'd1:  coef_o = 5'd2;
            7'd2:  coef_o = 5'd4;
            7'd3:  coef_o = 5'd0;
            7'd4:  coef_o = 5'd13;
            7'd5:  coef_o = 5'd22;
            7'd6:  coef_o = 5'd0;
            7'd7:  coef_o = 5'd4;
            7'd8:  coef_o = 5'd19;
            7'd9:  coef_o = 5'd0;
            7'd10: coef_o = 5'd3;
            7'd11: coef_o = 5'd14;
            7'd12: coef_o = 5'd0;
            7'd13: coef_o = 5'd27;
            7'd14: coef_o = 5'd31;
            7'd15: coef_o = 5'd0;
            7'd16: coef_o = 5'd3;
            7'd17: coef_o = 5'd8;
            7'd18: coef_o = 5'd0;
            7'd19: coef_o = 5'd17;
            7'd20: coef_o = 5'd26;
            7'd21: coef_o = 5'd0;
            7'd22: coef_o = 5'd3;
            7'd23: coef_o = 5'd12;
            7'd24: coef_o = 5'd0;
            7'd25: coef_o = 5'd18;
            7'd26: coef_o = 5'd22;
            7'd27: coef_o = 5'd0;
            7'd28: coef_o = 5'd12;
            7'd29: coef_o = 5'd18;
            7'd30: coef_o = 5'd0;
            7'd31: coef_o = 5'd4;
            7'd32: coef_o = 5'd7;
            7'd33: coef_o = 5'd0;
            7'd34: coef_o = 5'd4;
            7'd35: coef_o = 5'd31;
            7'd36: coef_o = 5'd0;
            7'd37: coef_o = 5'd12;
            7'd38: coef_o = 5'd27;
            7'd39: coef_o = 5'd0;
            7'd40: coef_o = 5'd7;
            7'd41: coef_o = 5'd17;
            7'd42: coef_o = 5'd0;
            7'd43: coef_o = 5'd7;
            7'd44: coef_o = 5'd8;
            7'd45: coef_o = 5'd0;
            7'd46: coef_o = 5'd1;
            7'd47: coef_o = 5'd13;
            default: coef_o = '0;
        endcase
    end

endmodule

// File: rtl/eaglesong_circulant_step.sv
// Iterative circulant multiply: each word becomes the XOR of three rotations of itself.
// 48 cycles after acceptance; result held in DONE until out_ready, no input queuing.
module eaglesong_circulant_step
    import eaglesong_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WORDS*WORD_W-1:0] in_state,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WORDS*WORD_W-1:0] out_state,
    output logic                    busy
);

    fsm_e                  fsm_q, fsm_d;
    state_t                state_q, state_d;
    logic [WORD_IDX_W-1:0] j_q, j_d;
    logic [K_W-1:0]        k_q, k_d;
    logic [WORD_W-1:0]     acc_q, acc_d;

    logic [COEF_IDX_W-1:0] coef_idx;
    logic [COEF_W-1:0]     coef;
    logic [WORD_W-1:0]     word_sel;
    logic [WORD_W-1:0]     term;

    // coef_idx = 3*j + k, built from shifts so it stays within 7 bits.
    assign coef_idx = ({3'b000, j_q} << 1) + {3'b000, j_q} + {5'b00000, k_q};

    eaglesong_coefficients u_coefs (
        .idx_i  (coef_idx),
        .coef_o (coef)
    );

    assign word_sel = state_q[j_q];
    assign term     = rotl32(word_sel, coef);

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        j_d     = j_q;
        k_d     = k_q;
        acc_d   = acc_q;
        case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    fsm_d   = RUN;
                    state_d = in_state;
                    j_d     = '0;
                    k_d     = '0;
                    acc_d   = '0;
                end
            end
            RUN: begin
                if (k_q == K_W'(COEFS_PER_WORD - 1)) begin
                    // Word j depends only on itself, so writing back in place is safe.
                    state_d[j_q] = acc_q ^ term;
                    acc_d        = '0;
                    k_d          = '0;
                    j_d          = j_q + 1'b1;
                    if (j_q == WORD_IDX_W'(WORDS - 1)) begin
                        fsm_d = DONE;
                    end
                end else begin
                    acc_d = acc_q ^ term;
                    k_d   = k_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            j_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            j_q     <= j_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
        end
    end

    assign in_ready  = (fsm_q == IDLE);
    assign busy      = (fsm_q == RUN);
    assign out_valid = (fsm_q == DONE);
    assign out_state = state_q;

endmodule

// File: tb/tb_eaglesong_circulant_step.sv
// Directed and random checks of the circulant stage against a bit-level reference model.
module tb_eaglesong_circulant_step;

    localparam int CYCLE_BUDGET = 200;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [511:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [511:0] out_state;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    int coef_tab [48] = '{
        0, 2, 4,    0, 13, 22,  0, 4, 19,   0, 3, 14,
        0, 27, 31,  0, 3, 8,    0, 17, 26,  0, 3, 12,
        0, 18, 22,  0, 12, 18,  0, 4, 7,    0, 4, 31,
        0, 12, 27,  0, 7, 17,   0, 7, 8,    0, 1, 13
    };

    eaglesong_circulant_step dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bit b of the input word lands at bit (b+c) mod 32 of the rotated term.
    function automatic logic [511:0] model(input logic [511:0] s);
        logic [511:0] r;
        r = '0;
        for (int j = 0; j < 16; j++) begin
            logic [31:0] w;
            logic [31:0] acc;
            w   = s[32*j +: 32];
            acc = '0;
            for (int k = 0; k < 3; k++) begin
                int c;
                c = coef_tab[3*j + k];
                for (int b = 0; b < 32; b++) begin
                    acc[(b + c) % 32] = acc[(b + c) % 32] ^ w[b];
                end
            end
            r[32*j +: 32] = acc;
        end
        return r;
    endfunction

    function automatic logic [511:0] rand_state();
        logic [511:0] s;
        for (int i = 0; i < 16; i++) s[32*i +: 32] = $urandom;
        return s;
    endfunction

    // Presents s, checks acceptance, the 48-cycle latency and the result; the output
    // handshake is left to the caller. Inputs change and outputs are sampled on negedge.
    task automatic issue_and_wait(input logic [511:0] s, input string tag, output int latency);
        int gate_viol;
        gate_viol = 0;
        latency   = -1;
        @(negedge clk);
        check({tag, "_in_ready"}, {511'b0, in_ready}, 512'd1);
        in_valid = 1'b1;
        in_state = s;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_state = rand_state();
        for (int n = 1; n <= CYCLE_BUDGET; n++) begin
            @(posedge clk);
            @(negedge clk);
            if ((busy || out_valid) && in_ready) gate_viol++;
            in_valid = $urandom_range(0, 1);
            if (out_valid) begin
                latency = n;
                break;
            end
        end
        in_valid = 1'b0;
        check({tag, "_latency"}, 512'(latency), 512'd48);
        check({tag, "_gate"}, 512'(gate_viol), 512'd0);
        check({tag, "_result"}, out_state, model(s));
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [511:0] s;
        logic [511:0] held;
        int lat;
        int stable_viol;
        int gate_viol;
        int n;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_state  = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_in_ready",  {511'b0, in_ready},  512'd1);
        check("reset_out_valid", {511'b0, out_valid}, 512'd0);
        check("reset_busy",      {511'b0, busy},      512'd0);
        check("reset_out_state", out_state,           512'd0);

        issue_and_wait('0, "zero", lat);
        check("zero_out", out_state, 512'd0);
        drain();

        for (int i = 0; i < 15; i++) s[32*i +: 32] = 32'h1;
        s[32*15 +: 32] = 32'h8000_0000;
        issue_and_wait(s, "onebit", lat);
        check("onebit_w0",  512'(out_state[0 +: 32]),    512'h0000_0015);
        check("onebit_w1",  512'(out_state[32 +: 32]),   512'h0040_2001);
        check("onebit_w15", 512'(out_state[480 +: 32]),  512'h8000_1001);
        drain();

        issue_and_wait({512{1'b1}}, "ones", lat);
        check("ones_out", out_state, {512{1'b1}});
        drain();

        // Backpressure: result must hold while in_valid pulses are ignored.
        s = rand_state();
        issue_and_wait(s, "bp", lat);
        held        = out_state;
        stable_viol = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_state = rand_state();
            @(posedge clk);
            @(negedge clk);
            if (out_state !== held || out_valid !== 1'b1 || in_ready !== 1'b0) stable_viol++;
        end
        check("bp_stable", 512'(stable_viol), 512'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_in_ready_after", {511'b0, in_ready},  512'd1);
        check("bp_out_valid_after", {511'b0, out_valid}, 512'd0);
        check("bp_state_kept", out_state, model(s));

        // Abort at RUN cycle 20.
        @(negedge clk);
        in_valid = 1'b1;
        in_state = rand_state();
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk);
        check("abort_busy_before", {511'b0, busy}, 512'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort_in_ready",  {511'b0, in_ready},  512'd1);
        check("abort_out_valid", {511'b0, out_valid}, 512'd0);
        check("abort_busy",      {511'b0, busy},      512'd0);
        check("abort_out_state", out_state,           512'd0);
        issue_and_wait(rand_state(), "post_abort", lat);
        drain();

        // Back-to-back random states with random output backpressure.
        gate_viol = 0;
        for (int t = 0; t < 100; t++) begin
            issue_and_wait(rand_state(), "rand", lat);
            held = out_state;
            n    = 0;
            while (n < CYCLE_BUDGET) begin
                out_ready = $urandom_range(0, 1);
                in_valid  = $urandom_range(0, 1);
                @(posedge clk);
                @(negedge clk);
                n++;
                if ((busy || out_valid) && in_ready) gate_viol++;
                if (!out_valid) break;
                if (out_state !== held) gate_viol++;
            end
            out_ready = 1'b0;
            in_valid  = 1'b0;
            check("rand_handshake", {511'b0, out_valid}, 512'd0);
        end
        check("rand_gate_total", 512'(gate_viol), 512'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
